ct_f_spsram_128x16_ctrl: RTL and testbench

Access controller for the 128x16 single-port SRAM macro. It zero-initialises the array after reset or on request, then shares the single port between two requesters with round-robin arbitration. It also drives the macro's active-low CEN/GWEN/WEN controls and returns read data one cycle after the access. It sits directly between the two client pipelines and one `ct_f_spsram_128x16` instance.

---
 rtl/ct_f_spsram_ctrl_pkg.sv | 16 +
 rtl/ct_f_spsram_rr_arb2.sv | 37 +++
 rtl/ct_f_spsram_128x16_ctrl.sv | 136 +++++++++++++
 tb/tb_ct_f_spsram_128x16_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_f_spsram_ctrl_pkg.sv
// Shared constants and state encoding for the 128x16 single-port SRAM controller.
package ct_f_spsram_ctrl_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 7;
  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_DEPTH      = 1 << DEFAULT_ADDR_WIDTH;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic                          CEN_OFF     = 1'b1;
  localparam logic [DEFAULT_DATA_WIDTH-1:0] WEN_ALL_OFF = '1;

endpackage

// File: rtl/ct_f_spsram_rr_arb2.sv
// Two-way round-robin arbiter; the preferred index flips to the loser after every grant.
module ct_f_spsram_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] vld,
  output logic [1:0] gnt
);

  logic prio_q;
  logic prio_d;

  // Grant selection and pointer update
  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    unique case (vld)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    if (gnt[0]) begin
      prio_d = 1'b1;
    end else if (gnt[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/ct_f_spsram_128x16_ctrl.sv
// Access controller for the 128x16 single-port SRAM: zero-fill sweep, then
// round-robin sharing of the port between two requesters with 1-cycle read return.
module ct_f_spsram_128x16_ctrl
  import ct_f_spsram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  req0_vld,
  input  logic                  req0_wr,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [DATA_WIDTH-1:0] req0_wmask,
  output logic                  req0_gnt,
  output logic                  req0_rdata_vld,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  input  logic                  req1_vld,
  input  logic                  req1_wr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [DATA_WIDTH-1:0] req1_wmask,
  output logic                  req1_gnt,
  output logic                  req1_rdata_vld,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] WEN_OFF  = {DATA_WIDTH{WEN_ALL_OFF[0]}};

  state_e                  state_q;
  state_e                  state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic [ADDR_WIDTH-1:0]   cnt_d;
  logic                    arb_en;
  logic [1:0]              arb_vld;
  logic [1:0]              gnt;
  logic [1:0]              rd_owner_vld;
  logic [1:0]              rd_owner_d;

  // Grants only in RUN, never while init_req or reset is asserted
  assign arb_en  = cpurst_b && (state_q == ST_RUN) && !init_req;
  assign arb_vld = {req1_vld, req0_vld} & {2{arb_en}};

  ct_f_spsram_rr_arb2 u_arb (
    .clk   (forever_cpuclk),
    .rst_n (cpurst_b),
    .vld   (arb_vld),
    .gnt   (gnt)
  );

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      rd_owner_vld <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_owner_vld <= rd_owner_d;
    end
  end

  // Sweep counter saturates at the last entry so RUN is entered once per sweep
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // SRAM port mux: sweep write, granted access, or idle
  always_comb begin
    sram_cen  = CEN_OFF;
    sram_gwen = 1'b1;
    sram_wen  = WEN_OFF;
    sram_a    = '0;
    sram_d    = '0;
    if (cpurst_b && (state_q == ST_INIT)) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = cnt_q;
    end else if (gnt[0]) begin
      sram_cen = 1'b0;
      sram_a   = req0_addr;
      if (req0_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = ~req0_wmask;
        sram_d    = req0_wdata;
      end
    end else if (gnt[1]) begin
      sram_cen = 1'b0;
      sram_a   = req1_addr;
      if (req1_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = ~req1_wmask;
        sram_d    = req1_wdata;
      end
    end
  end

  assign rd_owner_d = {gnt[1] & ~req1_wr, gnt[0] & ~req0_wr};

  assign init_done      = cpurst_b && (state_q == ST_RUN);
  assign req0_gnt       = gnt[0];
  assign req1_gnt       = gnt[1];
  assign req0_rdata_vld = cpurst_b && rd_owner_vld[0];
  assign req1_rdata_vld = cpurst_b && rd_owner_vld[1];
  assign req0_rdata     = req0_rdata_vld ? sram_q : '0;
  assign req1_rdata     = req1_rdata_vld ? sram_q : '0;

endmodule

// File: tb/tb_ct_f_spsram_128x16_ctrl.sv
// Bench for ct_f_spsram_128x16_ctrl: vector table, init/reset corner sequences,
// and randomized traffic against a spec-level reference model.
module tb_ct_f_spsram_128x16_ctrl;

  typedef struct {
    logic        init_req;
    logic        v0;
    logic        w0;
    logic [6:0]  a0;
    logic [15:0] d0;
    logic [15:0] m0;
    logic        v1;
    logic        w1;
    logic [6:0]  a1;
    logic [15:0] d1;
    logic [15:0] m1;
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic [15:0] rd0;
    logic [15:0] rd1;
  } vec_t;

  localparam logic [40:0] BUS_IDLE = {1'b1, 1'b1, 16'hFFFF, 7'h00, 16'h0000};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tinit;
  logic        tv[2];
  logic        tw[2];
  logic [6:0]  ta[2];
  logic [15:0] td[2];
  logic [15:0] tm[2];

  logic        init_done;
  logic        req0_gnt, req1_gnt, req0_rdata_vld, req1_rdata_vld;
  logic [15:0] req0_rdata, req1_rdata;
  logic        sram_cen, sram_gwen;
  logic [15:0] sram_wen, sram_d, sram_q;
  logic [6:0]  sram_a;
  logic [40:0] bus;
  logic [1:0]  gnt;

  logic [15:0] sram_mem[128];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ct_f_spsram_128x16_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .init_req       (tinit),
    .init_done      (init_done),
    .req0_vld       (tv[0]),
    .req0_wr        (tw[0]),
    .req0_addr      (ta[0]),
    .req0_wdata     (td[0]),
    .req0_wmask     (tm[0]),
    .req0_gnt       (req0_gnt),
    .req0_rdata_vld (req0_rdata_vld),
    .req0_rdata     (req0_rdata),
    .req1_vld       (tv[1]),
    .req1_wr        (tw[1]),
    .req1_addr      (ta[1]),
    .req1_wdata     (td[1]),
    .req1_wmask     (tm[1]),
    .req1_gnt       (req1_gnt),
    .req1_rdata_vld (req1_rdata_vld),
    .req1_rdata     (req1_rdata),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_a         (sram_a),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  assign bus = {sram_cen, sram_gwen, sram_wen, sram_a, sram_d};
  assign gnt = {req1_gnt, req0_gnt};

  // Behavioural SRAM macro: bit-masked write, registered read output
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) begin
        for (int b = 0; b < 16; b++) begin
          if (!sram_wen[b]) sram_mem[sram_a][b] <= sram_d[b];
        end
      end else begin
        sram_q <= sram_mem[sram_a];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [40:0] bus_acc(input logic wr, input logic [6:0] a,
                                          input logic [15:0] d, input logic [15:0] m);
    return wr ? {1'b0, 1'b0, ~m, a, d} : {1'b0, 1'b1, 16'hFFFF, a, 16'h0000};
  endfunction

  function automatic logic [40:0] bus_sweep(input int i);
    return {1'b0, 1'b0, 16'h0000, 7'(i), 16'h0000};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tinit = 1'b0;
    for (int n = 0; n < 2; n++) begin
      tv[n] = 1'b0; tw[n] = 1'b0; ta[n] = 7'h00; td[n] = 16'h0; tm[n] = 16'h0;
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic w, input logic [6:0] a,
                         input logic [15:0] d, input logic [15:0] m);
    tv[n] = v; tw[n] = w; ta[n] = a; td[n] = d; tm[n] = m;
  endtask

  // Check one whole sweep; requests stay pending to prove nothing is granted
  task automatic check_sweep(input string tag);
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      chk({tag, "_bus"}, 64'(bus), 64'(bus_sweep(i)));
      chk({tag, "_nognt_nodone"}, 64'({gnt, init_done}), 64'(0));
      next_cycle();
    end
  endtask

  vec_t tbl[$];

  bit          in_sweep;
  int          sw_idx;
  bit          pref;
  int          win;
  logic [15:0] ref_mem[128];
  bit          pend_v[2];
  logic [15:0] pend_d[2];
  bit          hold[2];
  logic [40:0] exp_bus;
  logic [1:0]  exp_gnt;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    set_req(0, 1'b1, 1'b0, 7'h03, 16'h0, 16'h0);
    set_req(1, 1'b1, 1'b1, 7'h04, 16'h1, 16'hFFFF);
    repeat (3) next_cycle();

    // Reset forces idle outputs even with requests pending
    @(negedge clk);
    chk("rst_bus", 64'(bus), 64'(BUS_IDLE));
    chk("rst_ctl", 64'({gnt, init_done, req0_rdata_vld, req1_rdata_vld}), 64'(0));
    chk("rst_rdata", 64'({req0_rdata, req1_rdata}), 64'(0));
    next_cycle();
    rst_n = 1'b1;
    check_sweep("init0");
    idle_inputs();
    @(negedge clk);
    chk("init0_done", 64'(init_done), 64'(1));
    next_cycle();

    // Directed table: init_req, v0,w0,a0,d0,m0, v1,w1,a1,d1,m1, gnt, rv, rd0, rd1
    tbl.push_back('{0, 1,1,7'h05,16'hA5A5,16'hFFFF, 0,0,7'h00,16'h0000,16'h0000, 2'b01, 2'b00, 16'h0000, 16'h0000});
    tbl.push_back('{0, 1,0,7'h05,16'h0000,16'h0000, 0,0,7'h00,16'h0000,16'h0000, 2'b01, 2'b00, 16'h0000, 16'h0000});
    tbl.push_back('{0, 1,1,7'h05,16'h1234,16'h00FF, 0,0,7'h00,16'h0000,16'h0000, 2'b01, 2'b01, 16'hA5A5, 16'h0000});
    tbl.push_back('{0, 0,0,7'h00,16'h0000,16'h0000, 1,0,7'h05,16'h0000,16'h0000, 2'b10, 2'b00, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0,0,7'h00,16'h0000,16'h0000, 0,0,7'h00,16'h0000,16'h0000, 2'b00, 2'b10, 16'h0000, 16'hA534});
    tbl.push_back('{0, 1,0,7'h05,16'h0000,16'h0000, 1,1,7'h10,16'hBEEF,16'hFFFF, 2'b01, 2'b00, 16'h0000, 16'h0000});
    tbl.push_back('{0, 1,0,7'h10,16'h0000,16'h0000, 1,1,7'h10,16'hBEEF,16'hFFFF, 2'b10, 2'b01, 16'hA534, 16'h0000});
    tbl.push_back('{0, 1,0,7'h10,16'h0000,16'h0000, 1,0,7'h11,16'h0000,16'h0000, 2'b01, 2'b00, 16'h0000, 16'h0000});
    tbl.push_back('{0, 1,0,7'h12,16'h0000,16'h0000, 1,0,7'h11,16'h0000,16'h0000, 2'b10, 2'b01, 16'hBEEF, 16'h0000});
    tbl.push_back('{0, 1,0,7'h12,16'h0000,16'h0000, 1,0,7'h13,16'h0000,16'h0000, 2'b01, 2'b10, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0,0,7'h00,16'h0000,16'h0000, 1,0,7'h13,16'h0000,16'h0000, 2'b10, 2'b01, 16'h0000, 16'h0000});
    tbl.push_back('{0, 1,1,7'h12,16'h5A5A,16'hF0F0, 1,1,7'h13,16'h1111,16'hFFFF, 2'b01, 2'b10, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0,0,7'h00,16'h0000,16'h0000, 1,1,7'h13,16'h1111,16'hFFFF, 2'b10, 2'b00, 16'h0000, 16'h0000});
    tbl.push_back('{0, 1,0,7'h12,16'h0000,16'h0000, 1,0,7'h13,16'h0000,16'h0000, 2'b01, 2'b00, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0,0,7'h00,16'h0000,16'h0000, 1,0,7'h13,16'h0000,16'h0000, 2'b10, 2'b01, 16'h5050, 16'h0000});
    tbl.push_back('{0, 0,0,7'h00,16'h0000,16'h0000, 0,0,7'h00,16'h0000,16'h0000, 2'b00, 2'b10, 16'h0000, 16'h1111});
    tbl.push_back('{0, 1,1,7'h05,16'hFFFF,16'h0000, 0,0,7'h00,16'h0000,16'h0000, 2'b01, 2'b00, 16'h0000, 16'h0000});
    tbl.push_back('{0, 1,0,7'h05,16'h0000,16'h0000, 0,0,7'h00,16'h0000,16'h0000, 2'b01, 2'b00, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0,0,7'h00,16'h0000,16'h0000, 0,0,7'h00,16'h0000,16'h0000, 2'b00, 2'b01, 16'hA534, 16'h0000});

    foreach (tbl[i]) begin
      tinit = tbl[i].init_req;
      set_req(0, tbl[i].v0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].m0);
      set_req(1, tbl[i].v1, tbl[i].w1, tbl[i].a1, tbl[i].d1, tbl[i].m1);
      if (tbl[i].gnt[0])      exp_bus = bus_acc(tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].m0);
      else if (tbl[i].gnt[1]) exp_bus = bus_acc(tbl[i].w1, tbl[i].a1, tbl[i].d1, tbl[i].m1);
      else                    exp_bus = BUS_IDLE;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", i), 64'(gnt), 64'(tbl[i].gnt));
      chk($sformatf("tbl%0d_bus", i), 64'(bus), 64'(exp_bus));
      chk($sformatf("tbl%0d_ret", i), 64'({req1_rdata_vld, req0_rdata_vld, req0_rdata, req1_rdata}),
          64'({tbl[i].rv, tbl[i].rd0, tbl[i].rd1}));
      next_cycle();
    end
    idle_inputs();

    // Read granted the cycle before init_req still returns; init_req blocks req1
    set_req(0, 1'b1, 1'b0, 7'h05, 16'h0, 16'h0);
    @(negedge clk);
    chk("pre_init_gnt", 64'(gnt), 64'(2'b01));
    next_cycle();
    idle_inputs();
    tinit = 1'b1;
    set_req(1, 1'b1, 1'b0, 7'h05, 16'h0, 16'h0);
    @(negedge clk);
    chk("init_req_gnt", 64'(gnt), 64'(2'b00));
    chk("init_req_bus", 64'(bus), 64'(BUS_IDLE));
    chk("init_req_ret", 64'({req0_rdata_vld, req0_rdata}), 64'({1'b1, 16'hA534}));
    next_cycle();
    tinit = 1'b0;
    for (int i = 0; i < 128; i++) begin
      tinit = (i == 50);
      @(negedge clk);
      chk("sweep1_bus", 64'(bus), 64'(bus_sweep(i)));
      chk("sweep1_nognt_nodone", 64'({gnt, init_done}), 64'(0));
      next_cycle();
    end
    tinit = 1'b0;
    @(negedge clk);
    chk("sweep1_done_gnt", 64'({init_done, gnt}), 64'({1'b1, 2'b10}));
    next_cycle();
    idle_inputs();
    set_req(0, 1'b1, 1'b0, 7'h12, 16'h0, 16'h0);
    @(negedge clk);
    chk("clr_gnt", 64'(gnt), 64'(2'b01));
    chk("clr_ret1", 64'({req1_rdata_vld, req1_rdata}), 64'({1'b1, 16'h0000}));
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("clr_ret0", 64'({req0_rdata_vld, req0_rdata}), 64'({1'b1, 16'h0000}));
    next_cycle();

    // Reset in the cycle after a read grant suppresses the return
    set_req(0, 1'b1, 1'b0, 7'h05, 16'h0, 16'h0);
    @(negedge clk);
    chk("rdrst_gnt", 64'(gnt), 64'(2'b01));
    next_cycle();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rdrst_ret", 64'({req0_rdata_vld, req0_rdata}), 64'(0));
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdrst_after", 64'({req0_rdata_vld, req1_rdata_vld}), 64'(0));
    chk("rdrst_sweep0", 64'(bus), 64'(bus_sweep(0)));
    next_cycle();

    // Reset when the sweep reaches entry 60, then a full restart from 0
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      chk("midrst_bus", 64'(bus), 64'(bus_sweep(i)));
      next_cycle();
    end
    rst_n = 1'b0;
    set_req(0, 1'b1, 1'b0, 7'h01, 16'h0, 16'h0);
    set_req(1, 1'b1, 1'b0, 7'h02, 16'h0, 16'h0);
    @(negedge clk);
    chk("midrst_idle", 64'(bus), 64'(BUS_IDLE));
    chk("midrst_ctl", 64'({gnt, init_done}), 64'(0));
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    idle_inputs();
    check_sweep("sweep2");
    @(negedge clk);
    chk("sweep2_done", 64'(init_done), 64'(1));

    // Randomized traffic against the reference model
    in_sweep = 1'b0; sw_idx = 0; pref = 1'b0;
    for (int i = 0; i < 128; i++) ref_mem[i] = 16'h0;
    for (int n = 0; n < 2; n++) begin pend_v[n] = 1'b0; pend_d[n] = 16'h0; hold[n] = 1'b0; end
    next_cycle();
    for (int c = 0; c < 2500; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!hold[n]) begin
          tv[n] = ($urandom % 4) != 0;
          tw[n] = 1'($urandom % 2);
          ta[n] = (($urandom % 4) == 0) ? 7'($urandom) : 7'($urandom % 8);
          td[n] = 16'($urandom);
          case ($urandom % 4)
            0:       tm[n] = 16'h0000;
            1:       tm[n] = 16'hFFFF;
            default: tm[n] = 16'($urandom);
          endcase
        end
      end
      tinit = ($urandom % 400) == 0;

      win = -1;
      if (!in_sweep && !tinit) begin
        if (tv[0] && tv[1]) win = pref ? 1 : 0;
        else if (tv[0])     win = 0;
        else if (tv[1])     win = 1;
      end
      exp_gnt = 2'b00;
      if (in_sweep)     exp_bus = bus_sweep(sw_idx);
      else if (win < 0) exp_bus = BUS_IDLE;
      else begin
        exp_gnt[win] = 1'b1;
        exp_bus = bus_acc(tw[win], ta[win], td[win], tm[win]);
      end

      @(negedge clk);
      chk("rnd_gnt", 64'(gnt), 64'(exp_gnt));
      chk("rnd_bus", 64'(bus), 64'(exp_bus));
      chk("rnd_done", 64'(init_done), 64'(!in_sweep));
      chk("rnd_ret", 64'({req1_rdata_vld, req0_rdata_vld, req0_rdata, req1_rdata}),
          64'({pend_v[1], pend_v[0], pend_v[0] ? pend_d[0] : 16'h0, pend_v[1] ? pend_d[1] : 16'h0}));

      for (int n = 0; n < 2; n++) pend_v[n] = 1'b0;
      if (in_sweep) begin
        ref_mem[sw_idx] = 16'h0;
        sw_idx++;
        if (sw_idx == 128) in_sweep = 1'b0;
      end else if (tinit) begin
        in_sweep = 1'b1;
        sw_idx = 0;
      end else if (win >= 0) begin
        pref = (win == 0);
        if (tw[win]) ref_mem[ta[win]] = (ref_mem[ta[win]] & ~tm[win]) | (td[win] & tm[win]);
        else begin
          pend_v[win] = 1'b1;
          pend_d[win] = ref_mem[ta[win]];
        end
      end
      for (int n = 0; n < 2; n++) hold[n] = tv[n] && (win != n);
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
